// File: rtl/sync_toggle_rx.sv
// sync_toggle_rx: destination endpoint of a two-phase toggle CDC handshake.
// Resynchronizes the sender's request toggle, captures the sender-held word
// into a 2-deep FIFO and returns an acknowledge toggle.
// Ports:
//   CLK, RST        destination clock, synchronous active-high reset
//   sREQ_TOGGLE     request toggle from the sender domain (asynchronous)
//   sD_IN           sender data, stable while its request is unacknowledged
//   dACK_TOGGLE     registered acknowledge toggle back to the sender
//   dDEQ            consumer dequeue, honored only while dEMPTY_N=1
//   dD_OUT          registered head-of-FIFO word
//   dEMPTY_N        registered "FIFO not empty" flag
module sync_toggle_rx #(
    parameter int dataWidth  = 1,
    parameter int syncStages = 2
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 sREQ_TOGGLE,
    input  logic [dataWidth-1:0] sD_IN,
    output logic                 dACK_TOGGLE,
    input  logic                 dDEQ,
    output logic [dataWidth-1:0] dD_OUT,
    output logic                 dEMPTY_N
);

    logic [syncStages-1:0] sync_q, sync_d;
    logic                  ack_q, ack_d;
    logic [1:0]            count_q, count_d;
    logic [dataWidth-1:0]  head_q, head_d;
    logic [dataWidth-1:0]  tail_q, tail_d;
    logic                  empty_n_q, empty_n_d;

    logic req_sync;
    logic pending;
    logic deq;
    logic space;
    logic capture;

    always_comb begin
        sync_d    = {sync_q[syncStages-2:0], sREQ_TOGGLE};
        ack_d     = ack_q;
        count_d   = count_q;
        head_d    = head_q;
        tail_d    = tail_q;

        req_sync  = sync_q[syncStages-1];
        pending   = req_sync ^ ack_q;
        deq       = dDEQ && (count_q != 2'd0);
        // A dequeue in the same cycle frees a slot, so a full FIFO can
        // still accept the pending word on that edge.
        space     = (count_q != 2'd2) || dDEQ;
        capture   = pending && space;

        if (capture) begin
            ack_d = ~ack_q;
        end

        case (count_q)
            2'd0: begin
                if (capture) begin
                    head_d  = sD_IN;
                    count_d = 2'd1;
                end
            end
            2'd1: begin
                if (deq && capture) begin
                    head_d = sD_IN;
                end else if (deq) begin
                    count_d = 2'd0;
                end else if (capture) begin
                    tail_d  = sD_IN;
                    count_d = 2'd2;
                end
            end
            2'd2: begin
                if (deq) begin
                    head_d = tail_q;
                    if (capture) begin
                        tail_d = sD_IN;
                    end else begin
                        count_d = 2'd1;
                    end
                end
            end
            default: begin
                count_d = 2'd0;
            end
        endcase

        empty_n_d = (count_d != 2'd0);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            sync_q    <= '0;
            ack_q     <= 1'b0;
            count_q   <= 2'd0;
            head_q    <= '0;
            tail_q    <= '0;
            empty_n_q <= 1'b0;
        end else begin
            sync_q    <= sync_d;
            ack_q     <= ack_d;
            count_q   <= count_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            empty_n_q <= empty_n_d;
        end
    end

    // Simulation-only notice: a dequeue on an empty FIFO is dropped.
    always_ff @(posedge CLK) begin
        if (!RST && dDEQ && !empty_n_q) begin
            $warning("sync_toggle_rx: dDEQ ignored while empty");
        end
    end

    assign dACK_TOGGLE = ack_q;
    assign dD_OUT      = head_q;
    assign dEMPTY_N    = empty_n_q;

endmodule

// File: tb/tb_sync_toggle_rx.sv
// Testbench for sync_toggle_rx (dataWidth=8, syncStages=2).
// Directed table, hand-written corner sequences and a randomized scoreboard.
module tb_sync_toggle_rx;

    logic       CLK = 1'b0;
    logic       RST;
    logic       sREQ_TOGGLE;
    logic [7:0] sD_IN;
    logic       dACK_TOGGLE;
    logic       dDEQ;
    logic [7:0] dD_OUT;
    logic       dEMPTY_N;

    int tests = 0;
    int fails = 0;

    sync_toggle_rx #(.dataWidth(8), .syncStages(2)) dut (
        .CLK(CLK),
        .RST(RST),
        .sREQ_TOGGLE(sREQ_TOGGLE),
        .sD_IN(sD_IN),
        .dACK_TOGGLE(dACK_TOGGLE),
        .dDEQ(dDEQ),
        .dD_OUT(dD_OUT),
        .dEMPTY_N(dEMPTY_N)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic       req;
        logic [7:0] din;
        logic       deq;
        logic       en;
        logic       ack;
        logic [7:0] dout;
    } vec_t;

    vec_t tbl[14];

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic flip_and_wait(logic [7:0] d, int n);
        sREQ_TOGGLE = ~sREQ_TOGGLE;
        sD_IN = d;
        repeat (n) tick();
    endtask

    // Sender waits for ack==req before each flip; consumer pops when not
    // empty. The scoreboard is simply the ordered list of words sent.
    task automatic run_random(int n, bit cont);
        logic [7:0] q[$];
        int sent = 0;
        int got = 0;
        int gap = 0;
        int cyc = 0;
        while ((sent < n || q.size() != 0) && cyc < 20000) begin
            dDEQ = 1'b0;
            if (dEMPTY_N && (cont || $urandom_range(0, 2) == 0)) begin
                if (q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL rand_extra: got word %0h expected none",
                             dD_OUT);
                end else begin
                    check("rand_order", dD_OUT, q.pop_front());
                    got++;
                end
                dDEQ = 1'b1;
            end
            if (sent < n && sREQ_TOGGLE == dACK_TOGGLE) begin
                if (gap == 0) begin
                    sD_IN = 8'($urandom);
                    sREQ_TOGGLE = ~sREQ_TOGGLE;
                    q.push_back(sD_IN);
                    sent++;
                    gap = cont ? 0 : $urandom_range(0, 3);
                end else begin
                    gap--;
                end
            end
            tick();
            cyc++;
        end
        dDEQ = 1'b0;
        if (cyc >= 20000) begin
            tests++;
            fails++;
            $display("FAIL rand_timeout: got %0d words expected %0d", got, n);
        end
        check("rand_count", got, n);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{1'b0, 8'h11, 1'b0, 1'b0, 1'b1, 8'h00};
        tbl[1]  = '{1'b0, 8'h11, 1'b0, 1'b0, 1'b1, 8'h00};
        tbl[2]  = '{1'b0, 8'h11, 1'b0, 1'b1, 1'b0, 8'h11};
        tbl[3]  = '{1'b1, 8'h22, 1'b0, 1'b1, 1'b0, 8'h11};
        tbl[4]  = '{1'b1, 8'h22, 1'b0, 1'b1, 1'b0, 8'h11};
        tbl[5]  = '{1'b1, 8'h22, 1'b0, 1'b1, 1'b1, 8'h11};
        tbl[6]  = '{1'b0, 8'h33, 1'b0, 1'b1, 1'b1, 8'h11};
        tbl[7]  = '{1'b0, 8'h33, 1'b0, 1'b1, 1'b1, 8'h11};
        tbl[8]  = '{1'b0, 8'h33, 1'b0, 1'b1, 1'b1, 8'h11};
        tbl[9]  = '{1'b0, 8'h33, 1'b0, 1'b1, 1'b1, 8'h11};
        tbl[10] = '{1'b0, 8'h33, 1'b1, 1'b1, 1'b0, 8'h22};
        tbl[11] = '{1'b0, 8'h33, 1'b1, 1'b1, 1'b0, 8'h33};
        tbl[12] = '{1'b0, 8'h33, 1'b1, 1'b0, 1'b0, 8'h00};
        tbl[13] = '{1'b0, 8'h33, 1'b0, 1'b0, 1'b0, 8'h00};

        RST = 1'b1;
        sREQ_TOGGLE = 1'b0;
        sD_IN = 8'h00;
        dDEQ = 1'b0;
        tick();
        tick();
        RST = 1'b0;
        check("rst_empty_n", dEMPTY_N, 0);
        check("rst_ack", dACK_TOGGLE, 0);
        check("rst_dout", dD_OUT, 0);

        for (int i = 0; i < 20; i++) begin
            tick();
            check("idle_empty_n", dEMPTY_N, 0);
            check("idle_ack", dACK_TOGGLE, 0);
            check("idle_dout", dD_OUT, 0);
        end

        sD_IN = 8'hA5;
        sREQ_TOGGLE = 1'b1;
        tick();
        check("a5_e0_empty_n", dEMPTY_N, 0);
        check("a5_e0_ack", dACK_TOGGLE, 0);
        tick();
        check("a5_e1_empty_n", dEMPTY_N, 0);
        check("a5_e1_ack", dACK_TOGGLE, 0);
        tick();
        check("a5_e2_empty_n", dEMPTY_N, 1);
        check("a5_e2_ack", dACK_TOGGLE, 1);
        check("a5_e2_dout", dD_OUT, 8'hA5);
        dDEQ = 1'b1;
        tick();
        dDEQ = 1'b0;
        check("a5_deq_empty_n", dEMPTY_N, 0);

        for (int i = 0; i < 14; i++) begin
            sREQ_TOGGLE = tbl[i].req;
            sD_IN = tbl[i].din;
            dDEQ = tbl[i].deq;
            tick();
            check($sformatf("tbl%0d_empty_n", i), dEMPTY_N, tbl[i].en);
            check($sformatf("tbl%0d_ack", i), dACK_TOGGLE, tbl[i].ack);
            if (tbl[i].en) begin
                check($sformatf("tbl%0d_dout", i), dD_OUT, tbl[i].dout);
            end
        end
        dDEQ = 1'b0;

        flip_and_wait(8'h44, 3);
        flip_and_wait(8'h55, 3);
        flip_and_wait(8'h66, 3);
        check("full_empty_n", dEMPTY_N, 1);
        check("full_ack", dACK_TOGGLE, 0);
        check("full_dout", dD_OUT, 8'h44);
        RST = 1'b1;
        tick();
        check("midrst_empty_n", dEMPTY_N, 0);
        check("midrst_ack", dACK_TOGGLE, 0);
        check("midrst_dout", dD_OUT, 0);
        RST = 1'b0;
        sREQ_TOGGLE = 1'b0;
        repeat (4) tick();
        check("postrst_empty_n", dEMPTY_N, 0);
        check("postrst_ack", dACK_TOGGLE, 0);

        dDEQ = 1'b1;
        tick();
        dDEQ = 1'b0;
        check("deq_empty_empty_n", dEMPTY_N, 0);
        check("deq_empty_ack", dACK_TOGGLE, 0);
        check("deq_empty_dout", dD_OUT, 0);
        flip_and_wait(8'h77, 3);
        check("after_empty_deq_empty_n", dEMPTY_N, 1);
        check("after_empty_deq_dout", dD_OUT, 8'h77);
        check("after_empty_deq_ack", dACK_TOGGLE, 1);
        dDEQ = 1'b1;
        tick();
        dDEQ = 1'b0;
        check("after_empty_deq_drain", dEMPTY_N, 0);

        run_random(256, 1'b1);
        run_random(64, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
